cpu_trace_monitor: RTL and testbench
====================================

// Module: cpu_trace_monitor
// PURPOSE
//  Synthesizable retirement-trace recorder for the 16-bit pipelined CPU. Samples MEM/WB-stage commit
//  events each cycle (reg write, mem read/write, halt), packs them into one record per cycle, and
//  buffers records in a FIFO drained over a valid/ready port. Also keeps cycle and instruction
//  counters, a no-halt watchdog, and drop/overflow accounting for on-chip or bench trace capture.
// PARAMETERS
//  DATA_W      16      register/memory data and address width
//  REG_AW      4       register index width
//  DEPTH       16      FIFO entries; power of 2, >=2
//  CYC_W       32      width of cycle_count, inst_count and record timestamp
//  WDOG_LIMIT  100000  cycles without halt before wdog_trip (must be < 2**CYC_W)
//  DROP_W      8       width of drop_count (saturating)
// PORTS
//  clk         in   1        clock, all state updates on rising edge
//  rst_n       in   1        reset, synchronous, active-low
//  clr         in   1        synchronous clear, same effect as reset
//  rf_we       in   1        register-file write this cycle
//  rf_waddr    in   REG_AW   destination register
//  rf_wdata    in   DATA_W   data written to register
//  mem_re      in   1        data-memory read this cycle
//  mem_we      in   1        data-memory write this cycle
//  mem_addr    in   DATA_W   data-memory address
//  mem_wdata   in   DATA_W   store data (to memory)
//  mem_rdata   in   DATA_W   load data (from memory)
//  hlt         in   1        halt instruction committed
//  trc_valid   out  1        head record available
//  trc_ready   in   1        consumer accepts head record
//  trc_flags   out  4        {hlt, mem_we, mem_re, rf_we} of head record
//  trc_reg     out  REG_AW   head rf_waddr
//  trc_rdata   out  DATA_W   head rf_wdata
//  trc_maddr   out  DATA_W   head mem_addr
//  trc_mdata   out  DATA_W   head mem data (wdata if mem_we, else rdata)
//  trc_cycle   out  CYC_W    cycle_count value when record was sampled
//  cycle_count out  CYC_W    cycles elapsed since reset/clr
//  inst_count  out  CYC_W    instructions retired
//  drop_count  out  DROP_W   records lost to full FIFO, saturates at all-ones
//  overflow    out  1        sticky: at least one record dropped
//  proto_err   out  1        sticky: mem_re & mem_we seen in same cycle
//  wdog_trip   out  1        sticky: WDOG_LIMIT reached without halt
//  done        out  1        sticky: halt seen or watchdog tripped
// BEHAVIOUR
//  - Reset/clr (rst_n=0 or clr=1 at edge): FIFO empty, all counters 0, all sticky flags 0,
//    trc_valid=0, trc_* data outputs 0. Reset wins over clr. Mid-operation reset discards all records.
//  - Active when !done. Each active cycle: cycle_count += 1 (record timestamp = pre-increment value).
//  - Event = rf_we|mem_re|mem_we|hlt. On an active-cycle event: one record pushed; inst_count += 1
//    if hlt|rf_we|mem_we (loads counted via their rf_we, not mem_re).
//  - mem_re&mem_we: record both flags, trc_mdata = mem_wdata, proto_err set.
//  - hlt: record pushed, then done=1 from next cycle; counters freeze; later inputs ignored.
//  - Watchdog: cycle_count reaching WDOG_LIMIT with no halt sets wdog_trip=1, done=1 next cycle;
//    no record written for the trip itself.
//  - While done, the FIFO still drains normally; only clr/reset restarts capture.
//  - FIFO: first-word-fall-through, registered outputs. Push at edge N into empty FIFO ->
//    trc_valid=1 after edge N. Pop when trc_valid&trc_ready at edge. trc_* stable while
//    trc_valid&!trc_ready.
//  - Full: push with no pop -> record dropped, drop_count += 1 (saturating), overflow=1; counters
//    still update; halt still sets done. Full with simultaneous pop+push: both accepted, count stays DEPTH.
//  - Pointers log2(DEPTH) bits, wrap mod DEPTH; occupancy tracked with extra bit to distinguish full/empty.
// TESTING
//  1. Reset, rf_we=1 r3<=0x00A5 at cycle 0, trc_ready=1 -> one record flags=0001 reg=3 rdata=0x00A5
//     trc_cycle=0; inst_count=1.
//  2. mem_we addr 0x0040 wdata 0x1234, then mem_re+rf_we r2 addr 0x0040 rdata 0x1234 -> two records
//     flags 0100 and 0011, inst_count=2.
//  3. trc_ready=0, DEPTH+3 consecutive rf_we events -> DEPTH held, drop_count=3, overflow=1;
//     drain returns first DEPTH records in order, trc_cycle 0..DEPTH-1.
//  4. Full FIFO, trc_ready=1 with push same cycle -> no drop, occupancy stays DEPTH.
//  5. hlt at cycle 10 with rf_we -> record flags 1001, done=1, cycle_count frozen at 11, later events ignored.
//  6. WDOG_LIMIT=50, no hlt -> wdog_trip=1 and done=1 at cycle_count 50; clr then restarts counts at 0.

Source files
------------

// File: rtl/cpu_trace_monitor.sv
// Retirement-trace recorder: packs MEM/WB commit events into per-cycle records, buffers them in a
// first-word-fall-through FIFO with registered outputs, and keeps cycle/instruction/drop accounting.
module cpu_trace_monitor #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 32,
  parameter int WDOG_LIMIT = 100000,
  parameter int DROP_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rf_we,
  input  logic [REG_AW-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              hlt,
  output logic              trc_valid,
  input  logic              trc_ready,
  output logic [3:0]        trc_flags,
  output logic [REG_AW-1:0] trc_reg,
  output logic [DATA_W-1:0] trc_rdata,
  output logic [DATA_W-1:0] trc_maddr,
  output logic [DATA_W-1:0] trc_mdata,
  output logic [CYC_W-1:0]  trc_cycle,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [CYC_W-1:0]  inst_count,
  output logic [DROP_W-1:0] drop_count,
  output logic              overflow,
  output logic              proto_err,
  output logic              wdog_trip,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CYC_W-1:0] WDOG_LAST = CYC_W'(WDOG_LIMIT - 1);

  typedef struct packed {
    logic [3:0]        flags;
    logic [REG_AW-1:0] rg;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] maddr;
    logic [DATA_W-1:0] mdata;
    logic [CYC_W-1:0]  cyc;
  } rec_t;

  rec_t              mem_q [DEPTH];
  rec_t              head_q, head_d, new_rec;
  logic              valid_q, valid_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, left_after_pop;
  logic [CYC_W-1:0]  cycle_q, inst_q;
  logic [DROP_W-1:0] drop_q;
  logic              overflow_q, proto_q, wdog_q, done_q;
  logic              active, push, pop, full, push_ok, drop, wdog_hit;

  // NOTE: every combinational output gets a default at the top of the block so no latch is inferred.
  always_comb begin
    active   = !done_q;
    push     = active && (rf_we || mem_re || mem_we || hlt);
    pop      = valid_q && trc_ready;
    full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    push_ok  = push && (!full || pop);
    drop     = push && full && !pop;
    wdog_hit = active && !hlt && (cycle_q == WDOG_LAST);

    new_rec.flags = {hlt, mem_we, mem_re, rf_we};
    new_rec.rg    = rf_waddr;
    new_rec.rdata = rf_wdata;
    new_rec.maddr = mem_addr;
    new_rec.mdata = mem_we ? mem_wdata : mem_rdata;
    new_rec.cyc   = cycle_q;

    wr_ptr_d       = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d       = rd_ptr_q + {{AW{1'b0}}, pop};
    left_after_pop = wr_ptr_q - rd_ptr_d;
    valid_d        = wr_ptr_d != rd_ptr_d;

    // The output register always mirrors the next head; bypass when the pushed record becomes head.
    head_d = '0;
    if (valid_d) begin
      if (left_after_pop == '0) head_d = new_rec;
      else                      head_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  // NOTE: record storage carries no reset; pointers define validity and the head register bypasses it.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= new_rec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      head_q     <= '0;
      valid_q    <= 1'b0;
      cycle_q    <= '0;
      inst_q     <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      proto_q    <= 1'b0;
      wdog_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      if (active) begin
        cycle_q <= cycle_q + 1'b1;
        if (hlt || rf_we || mem_we) inst_q <= inst_q + 1'b1;
        if (mem_re && mem_we)       proto_q <= 1'b1;
        if (hlt || wdog_hit)        done_q  <= 1'b1;
        if (wdog_hit)               wdog_q  <= 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign trc_valid   = valid_q;
  assign trc_flags   = head_q.flags;
  assign trc_reg     = head_q.rg;
  assign trc_rdata   = head_q.rdata;
  assign trc_maddr   = head_q.maddr;
  assign trc_mdata   = head_q.mdata;
  assign trc_cycle   = head_q.cyc;
  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign drop_count  = drop_q;
  assign overflow    = overflow_q;
  assign proto_err   = proto_q;
  assign wdog_trip   = wdog_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: a vector table for per-cycle records plus hand sequences
// for overflow, full pop+push, halt freeze, watchdog and mid-run reset.
module tb_cpu_trace_monitor;

  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic        rf_we, mem_re, mem_we, hlt, trc_ready;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata, mem_addr, mem_wdata, mem_rdata;
  logic        trc_valid, overflow, proto_err, wdog_trip, done;
  logic [3:0]  trc_flags, trc_reg;
  logic [15:0] trc_rdata, trc_maddr, trc_mdata;
  logic [31:0] trc_cycle, cycle_count, inst_count;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;

  cpu_trace_monitor #(.DATA_W(16), .REG_AW(4), .DEPTH(16), .CYC_W(32),
                      .WDOG_LIMIT(50), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_flags(trc_flags),
    .trc_reg(trc_reg), .trc_rdata(trc_rdata), .trc_maddr(trc_maddr),
    .trc_mdata(trc_mdata), .trc_cycle(trc_cycle), .cycle_count(cycle_count),
    .inst_count(inst_count), .drop_count(drop_count), .overflow(overflow),
    .proto_err(proto_err), .wdog_trip(wdog_trip), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rf_we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic        mem_re, mem_we;
    logic [15:0] addr, mwdata, mrdata;
    logic        ready;
    logic        e_valid;
    logic [3:0]  e_flags, e_reg;
    logic [15:0] e_rdata, e_maddr, e_mdata;
    logic [31:0] e_cyc, e_inst;
  } vec_t;

  localparam logic        O  = 1'b0;
  localparam logic        I  = 1'b1;
  localparam logic [3:0]  R0 = 4'd0;
  localparam logic [15:0] Z  = 16'h0000;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0; mem_re = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_rdata = '0; hlt = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic push_reg(input logic [3:0] r, input logic [15:0] d);
    idle();
    rf_we = 1'b1; rf_waddr = r; rf_wdata = d;
    tick();
  endtask

  initial begin
    int n;
    logic [15:0] last;

    vecs[0] = '{I,4'd3,16'h00A5, O,O,Z,Z,Z, I, I,4'b0001,4'd3,16'h00A5,Z,Z,32'd0,32'd1};
    vecs[1] = '{O,R0,Z, O,I,16'h0040,16'h1234,Z, I, I,4'b0100,R0,Z,16'h0040,16'h1234,32'd1,32'd2};
    vecs[2] = '{I,4'd2,16'h1234, I,O,16'h0040,Z,16'h1234, I,
                I,4'b0011,4'd2,16'h1234,16'h0040,16'h1234,32'd2,32'd3};
    vecs[3] = '{O,R0,Z, O,O,Z,Z,Z, I, O,4'b0000,R0,Z,Z,Z,32'd0,32'd3};
    vecs[4] = '{O,R0,Z, I,O,16'h0080,16'h5555,16'hBEEF, I,
                I,4'b0010,R0,Z,16'h0080,16'hBEEF,32'd4,32'd3};
    vecs[5] = '{O,R0,Z, I,I,16'h0010,16'hCAFE,16'h1111, I,
                I,4'b0110,R0,Z,16'h0010,16'hCAFE,32'd5,32'd4};
    vecs[6] = '{I,4'd15,16'hFFFF, O,O,Z,Z,Z, O, I,4'b0110,R0,Z,16'h0010,16'hCAFE,32'd5,32'd5};
    vecs[7] = '{O,R0,Z, O,O,Z,Z,Z, O, I,4'b0110,R0,Z,16'h0010,16'hCAFE,32'd5,32'd5};
    vecs[8] = '{O,R0,Z, O,O,Z,Z,Z, I, I,4'b0001,4'd15,16'hFFFF,Z,Z,32'd6,32'd5};
    vecs[9] = '{O,R0,Z, O,O,Z,Z,Z, I, O,4'b0000,R0,Z,Z,Z,32'd0,32'd5};

    // Reset with an event present: nothing may be captured.
    idle();
    rst_n = 1'b0; clr = 1'b0; trc_ready = 1'b1; rf_we = 1'b1;
    tick(); tick();
    check("rst valid", trc_valid, 0);
    check("rst cycle", cycle_count, 0);
    check("rst inst", inst_count, 0);
    check("rst drop", drop_count, 0);
    check("rst flags", {overflow, proto_err, wdog_trip, done}, 0);
    check("rst data", {trc_flags, trc_reg, trc_rdata, trc_maddr, trc_mdata, trc_cycle}, 0);
    idle();
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      rf_we = vecs[k].rf_we; rf_waddr = vecs[k].waddr; rf_wdata = vecs[k].wdata;
      mem_re = vecs[k].mem_re; mem_we = vecs[k].mem_we; mem_addr = vecs[k].addr;
      mem_wdata = vecs[k].mwdata; mem_rdata = vecs[k].mrdata; hlt = 1'b0;
      trc_ready = vecs[k].ready;
      tick();
      check($sformatf("vec%0d valid", k), trc_valid, vecs[k].e_valid);
      if (vecs[k].e_valid) begin
        check($sformatf("vec%0d flags", k), trc_flags, vecs[k].e_flags);
        check($sformatf("vec%0d reg", k), trc_reg, vecs[k].e_reg);
        check($sformatf("vec%0d rdata", k), trc_rdata, vecs[k].e_rdata);
        check($sformatf("vec%0d maddr", k), trc_maddr, vecs[k].e_maddr);
        check($sformatf("vec%0d mdata", k), trc_mdata, vecs[k].e_mdata);
        check($sformatf("vec%0d tcyc", k), trc_cycle, vecs[k].e_cyc);
      end
      check($sformatf("vec%0d cycle", k), cycle_count, 32'(k + 1));
      check($sformatf("vec%0d inst", k), inst_count, vecs[k].e_inst);
    end
    check("vec proto_err", proto_err, 1);
    check("vec overflow", overflow, 0);

    // Overflow: DEPTH+3 pushes with no consumer, then ordered drain.
    idle(); trc_ready = 1'b0;
    do_clr();
    check("clr proto", proto_err, 0);
    for (int i = 0; i < 19; i++) push_reg(4'(i), 16'(i));
    idle();
    check("ovf valid", trc_valid, 1);
    check("ovf drop", drop_count, 3);
    check("ovf sticky", overflow, 1);
    check("ovf inst", inst_count, 19);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d valid", i), trc_valid, 1);
      check($sformatf("drain%0d tcyc", i), trc_cycle, 32'(i));
      check($sformatf("drain%0d rdata", i), trc_rdata, 16'(i));
      trc_ready = 1'b1;
      tick();
    end
    check("drain empty", trc_valid, 0);

    // Full FIFO with simultaneous pop and push keeps occupancy at DEPTH.
    trc_ready = 1'b0;
    do_clr();
    for (int i = 0; i < 16; i++) push_reg(4'd1, 16'h0100 + 16'(i));
    check("full drop0", drop_count, 0);
    trc_ready = 1'b1;
    push_reg(4'd2, 16'h0077);
    check("full pp drop", drop_count, 0);
    check("full pp head", trc_cycle, 1);
    trc_ready = 1'b0;
    push_reg(4'd2, 16'h0088);
    check("full still", drop_count, 1);
    idle(); trc_ready = 1'b1;
    n = 0; last = '0;
    for (int j = 0; j < 20; j++) begin
      if (trc_valid) begin n++; last = trc_rdata; end
      tick();
    end
    check("full count", n, 16);
    check("full last", last, 16'h0077);

    // Halt at cycle 10 freezes capture.
    do_clr();
    repeat (10) tick();
    rf_we = 1'b1; rf_waddr = 4'd1; rf_wdata = 16'h0042; hlt = 1'b1;
    tick();
    check("hlt valid", trc_valid, 1);
    check("hlt flags", trc_flags, 4'b1001);
    check("hlt tcyc", trc_cycle, 10);
    check("hlt done", done, 1);
    check("hlt cycle", cycle_count, 11);
    check("hlt inst", inst_count, 1);
    idle(); rf_we = 1'b1; mem_we = 1'b1;
    repeat (5) tick();
    check("hlt ignore valid", trc_valid, 0);
    check("hlt frozen cycle", cycle_count, 11);
    check("hlt frozen inst", inst_count, 1);
    check("hlt no wdog", wdog_trip, 0);
    idle();

    // Watchdog trips as cycle_count reaches 50, then clr restarts.
    do_clr();
    repeat (49) tick();
    check("wdog pre done", done, 0);
    check("wdog pre cycle", cycle_count, 49);
    tick();
    check("wdog trip", wdog_trip, 1);
    check("wdog done", done, 1);
    check("wdog cycle", cycle_count, 50);
    check("wdog norec", trc_valid, 0);
    repeat (3) tick();
    check("wdog frozen", cycle_count, 50);
    do_clr();
    check("wclr cycle", cycle_count, 0);
    check("wclr flags", {wdog_trip, done}, 0);
    tick();
    check("wclr count", cycle_count, 1);

    // Mid-run reset discards buffered records.
    trc_ready = 1'b0;
    repeat (3) push_reg(4'd5, 16'h5A5A);
    check("mid valid", trc_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    check("mid rst valid", trc_valid, 0);
    check("mid rst inst", inst_count, 0);
    check("mid rst cycle", cycle_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
